// File: rtl/iodelay_pkg.sv
// Encodings shared by the tap responder and the calibration controllers that drive it.
package iodelay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_ADJ  = 2'd2
  } iod_state_e;

  // What a RST request loads into the tap counter.
  localparam int RST_MODE_ZERO = 0;  // tap <= 0
  localparam int RST_MODE_HALF = 1;  // tap <= cal_val >> 1

  localparam int TAP_W_DEF = 8;

endpackage

// File: rtl/iodelay_tap_line.sv
// Delay line: data_in delayed by tap+1 clk cycles through a registered tap mux.
module iodelay_tap_line #(
  parameter int TAP_W   = 8,
  parameter int MAX_TAP = 255   // must be >= 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_in,
  input  logic [TAP_W-1:0] tap,
  output logic             data_out
);

  // taps[k] is data_in as seen k cycles ago; taps[0] is the live input, so
  // the line has MAX_TAP+1 selectable points and the output register adds
  // the final cycle of latency.
  logic [MAX_TAP-1:0] sr;
  logic [MAX_TAP:0]   taps;

  assign taps = {sr, data_in};

  // Shift every cycle and register the selected point.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr       <= '0;
      data_out <= 1'b0;
    end else begin
      sr       <= taps[MAX_TAP-1:0];
      data_out <= taps[tap];
    end
  end

endmodule

// File: rtl/iodelay_tap_responder.sv
// Responder side of the CAL/RST/CE/INC/BUSY delay-element handshake, with a
// tap counter driving a single-bit delay line.
module iodelay_tap_responder
  import iodelay_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int MAX_TAP    = 255,
  parameter int CAL_CYCLES = 8,
  parameter int ADJ_CYCLES = 2,
  parameter int CAL_RESULT = 200,
  parameter int WRAPAROUND = 1,
  parameter int RST_MODE   = RST_MODE_ZERO
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cal,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  output logic             busy,
  input  logic             data_in,
  output logic             data_out,
  output logic [TAP_W-1:0] tap_out,
  output logic             proto_err
);

  localparam int CNT_MAX = (CAL_CYCLES > ADJ_CYCLES) ? CAL_CYCLES : ADJ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_CAL = TAP_W'(CAL_RESULT);

  iod_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [TAP_W-1:0] tap, tap_d, tap_up, tap_dn;
  logic [TAP_W-1:0] cal_val, cal_val_d;
  logic             err_d;

  // State, busy countdown and the registered busy flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      busy  <= (state_d != ST_IDLE);
    end
  end

  // Next state: requests are only accepted in IDLE; cal beats rst beats ce,
  // and rst is instantaneous so it never leaves IDLE.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (cal) begin
          state_d = ST_CAL;
          cnt_d   = CNT_W'(CAL_CYCLES - 1);
        end else if (!rst && ce) begin
          state_d = ST_ADJ;
          cnt_d   = CNT_W'(ADJ_CYCLES - 1);
        end
      end
      ST_CAL, ST_ADJ: begin
        if (cnt == '0) state_d = ST_IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Boundary behaviour of a single-step adjust.
  assign tap_up = (tap == TAP_MAX) ? ((WRAPAROUND != 0) ? '0 : TAP_MAX) : tap + TAP_W'(1);
  assign tap_dn = (tap == '0) ? ((WRAPAROUND != 0) ? TAP_MAX : '0) : tap - TAP_W'(1);

  // Datapath actions and protocol-violation detection.
  always_comb begin
    tap_d     = tap;
    cal_val_d = cal_val;
    err_d     = proto_err;
    if (state == ST_IDLE) begin
      // More than one request at once: the loser(s) are dropped.
      if ((cal && rst) || (cal && ce) || (rst && ce)) err_d = 1'b1;
      if (cal) begin
        tap_d = tap;
      end else if (rst) begin
        tap_d = (RST_MODE == RST_MODE_HALF) ? (cal_val >> 1) : '0;
      end else if (ce) begin
        tap_d = inc ? tap_up : tap_dn;
      end
    end else begin
      if (cal || rst || ce) err_d = 1'b1;
      // Calibration result lands on the last busy cycle only, so an
      // interrupted calibration leaves cal_val untouched.
      if (state == ST_CAL && cnt == '0) cal_val_d = TAP_CAL;
    end
  end

  // Tap counter, calibration result and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tap       <= '0;
      cal_val   <= TAP_MAX;
      proto_err <= 1'b0;
    end else begin
      tap       <= tap_d;
      cal_val   <= cal_val_d;
      proto_err <= err_d;
    end
  end

  assign tap_out = tap;

  iodelay_tap_line #(
    .TAP_W   (TAP_W),
    .MAX_TAP (MAX_TAP)
  ) u_line (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (data_in),
    .tap      (tap),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_iodelay_tap_responder.sv
// Scoreboard bench: two responders (wrap + RST loads cal_val/2, saturate + RST
// loads 0) share one stimulus stream; a behavioural model predicts every
// cycle's outputs and a monitor compares them after each clock edge.
module tb_iodelay_tap_responder;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic cal = 1'b0, rst = 1'b0, ce = 1'b0, inc = 1'b0, data_in = 1'b0;
  logic busy_a, dout_a, err_a, busy_b, dout_b, err_b;
  logic [7:0] tap_a, tap_b;

  always #5 clk = ~clk;

  iodelay_tap_responder #(
    .TAP_W(8), .MAX_TAP(255), .CAL_CYCLES(8), .ADJ_CYCLES(2),
    .CAL_RESULT(200), .WRAPAROUND(1), .RST_MODE(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .cal(cal), .rst(rst), .ce(ce), .inc(inc),
    .busy(busy_a), .data_in(data_in), .data_out(dout_a), .tap_out(tap_a),
    .proto_err(err_a)
  );

  iodelay_tap_responder #(
    .TAP_W(8), .MAX_TAP(255), .CAL_CYCLES(8), .ADJ_CYCLES(2),
    .CAL_RESULT(200), .WRAPAROUND(0), .RST_MODE(0)
  ) dut_b (
    .clk(clk), .resetn(resetn), .cal(cal), .rst(rst), .ce(ce), .inc(inc),
    .busy(busy_b), .data_in(data_in), .data_out(dout_b), .tap_out(tap_b),
    .proto_err(err_b)
  );

  typedef struct {
    logic       busy;
    logic [7:0] tap;
    logic       dout;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: busy as "cycles of busy still to show", tap as an int,
  // delay as an input history indexed by the tap.
  int wrap_p[2]  = '{1, 0};
  int rstm_p[2]  = '{1, 0};
  int m_left[2];
  int m_tap[2];
  int m_cal[2];
  bit m_pend[2];
  bit m_err[2];
  bit m_dout[2];
  bit hist[256];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_tap[i] = 0; m_cal[i] = 255;
      m_pend[i] = 1'b0; m_err[i] = 1'b0; m_dout[i] = 1'b0;
    end
    for (int k = 0; k < 256; k++) hist[k] = 1'b0;
  endfunction

  function automatic void model_step(bit c, bit r, bit e, bit up, bit d);
    int nreq;
    for (int k = 255; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    nreq = int'(c) + int'(r) + int'(e);
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = hist[m_tap[i]];
      if (m_left[i] == 0) begin
        if (nreq > 1) m_err[i] = 1'b1;
        if (c) begin
          m_left[i] = 8;
          m_pend[i] = 1'b1;
        end else if (r) begin
          m_tap[i] = (rstm_p[i] == 1) ? m_cal[i] / 2 : 0;
        end else if (e) begin
          if (up) m_tap[i] = (m_tap[i] == 255) ? ((wrap_p[i] == 1) ? 0 : 255) : m_tap[i] + 1;
          else    m_tap[i] = (m_tap[i] == 0)   ? ((wrap_p[i] == 1) ? 255 : 0) : m_tap[i] - 1;
          m_left[i] = 2;
        end
      end else begin
        if (nreq > 0) m_err[i] = 1'b1;
        m_left[i]--;
        if (m_left[i] == 0 && m_pend[i]) begin
          m_cal[i]  = 200;
          m_pend[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, enqueue expectation.
  task automatic cyc(input bit c, input bit r, input bit e, input bit up, input bit d);
    exp_t x;
    @(negedge clk);
    cal = c; rst = r; ce = e; inc = up; data_in = d;
    model_step(c, r, e, up, d);
    x.busy = (m_left[0] > 0); x.tap = 8'(m_tap[0]); x.dout = m_dout[0]; x.err = m_err[0];
    q_a.push_back(x);
    x.busy = (m_left[1] > 0); x.tap = 8'(m_tap[1]); x.dout = m_dout[1]; x.err = m_err[1];
    q_b.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic check_reset_vals();
    chk("rst_busy_a", int'(busy_a), 0); chk("rst_tap_a", int'(tap_a), 0);
    chk("rst_dout_a", int'(dout_a), 0); chk("rst_err_a", int'(err_a), 0);
    chk("rst_busy_b", int'(busy_b), 0); chk("rst_tap_b", int'(tap_b), 0);
    chk("rst_dout_b", int'(dout_b), 0); chk("rst_err_b", int'(err_b), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    cal = 1'b0; rst = 1'b0; ce = 1'b0; inc = 1'b0; data_in = 1'b0;
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    q_a.delete(); q_b.delete();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: every edge the DUTs present a new output word.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (resetn) begin
        if (q_a.size() > 0) begin
          x = q_a.pop_front();
          chk("busy_a", int'(busy_a), int'(x.busy)); chk("tap_a", int'(tap_a), int'(x.tap));
          chk("dout_a", int'(dout_a), int'(x.dout)); chk("err_a", int'(err_a), int'(x.err));
        end
        if (q_b.size() > 0) begin
          x = q_b.pop_front();
          chk("busy_b", int'(busy_b), int'(x.busy)); chk("tap_b", int'(tap_b), int'(x.tap));
          chk("dout_b", int'(dout_b), int'(x.dout)); chk("err_b", int'(err_b), int'(x.err));
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 resetn = 1'b0;
    #2 check_reset_vals();
    @(negedge clk);
    resetn = 1'b1;
    idle(5);

    // Calibration, then RST: wrap instance loads 200/2 = 100.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Walk up past MAX_TAP: wrap instance wraps, saturating instance pins at 255.
    // ce every third call lands on the cycle busy falls.
    for (int k = 0; k < 260; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom));
      idle(2);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Walk down past 0: wrap instance goes to 255, saturating instance holds 0.
    for (int k = 0; k < 103; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
      idle(2);
    end

    // Delay path: tap 3 on the saturating instance, isolated single-cycle pulses.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Protocol violations: ce during CAL, then cal+ce together in IDLE.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Reset during calibration: cal_val must stay at MAX_TAP, so RST gives 127.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++)
      cyc(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    idle(3);
    @(negedge clk);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
